sram189_ctrl: RTL and testbench
===============================

// Module: sram189_ctrl
// PURPOSE
//  Synchronous initiator for the 74189-style 16x4 async RAM. Two chips in parallel
//  form a 16x8 program/data RAM. Converts a valid/ready request from the SAP bus into
//  glitch-free, timed active-low CS/WE strobes. Re-inverts the chips' inverted outputs
//  so the bus sees true data. Sits between the SAP control sequencer/loader and the RAM chips.
// PARAMETERS
//  AW         4  address width (16 words)
//  DW         8  data width (DW/4 chips, nibble-sliced)
//  SETUP_CYC  1  cycles addr/data/CS stable before WE falls (>=1)
//  PULSE_CYC  2  cycles WE held low (>=1)
//  HOLD_CYC   1  cycles addr/data/CS held after WE rises (>=1)
//  READ_CYC   2  cycles CS low before read data sampled (>=1)
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   controller idle, accepts request
//  req_we     in   1   1=write, 0=read
//  req_addr   in   AW  word address
//  req_wdata  in   DW  write data
//  rsp_valid  out  1   one-cycle completion pulse (reads and writes)
//  rsp_rdata  out  DW  true (non-inverted) read data
//  busy       out  1   transaction in progress (state != IDLE)
//  ram_a      out  AW  RAM address pins
//  ram_d      out  DW  RAM data-in pins
//  ram_cs_n   out  1   RAM chip select, active low
//  ram_we_n   out  1   RAM write enable, active low
//  ram_o_n    in   DW  RAM inverted data outputs
// BEHAVIOUR
//  - All ram_* outputs, rsp_valid and rsp_rdata are registered (no combinational strobes).
//  - Reset: state=IDLE, ram_cs_n=1, ram_we_n=1, ram_a=0, ram_d=0, rsp_valid=0,
//    rsp_rdata=0, busy=0. req_ready=(state==IDLE), so it is 1 from the first post-reset cycle.
//  - Accept on posedge with req_valid&&req_ready. Latch addr, wdata and we. Request inputs
//    are ignored in all other states.
//  - FSM: IDLE -> (we) SETUP -> PULSE -> HOLD -> RESP -> IDLE
//             IDLE -> (!we) READ -> RESP -> IDLE
//  - SETUP (SETUP_CYC cycles): cs_n=0, we_n=1, ram_a/ram_d driven with the latched values.
//  - PULSE (PULSE_CYC): we_n=0. The chip commits on the WE falling edge; a/d stay stable.
//  - HOLD (HOLD_CYC): we_n=1, cs_n=0, a/d unchanged.
//  - READ (READ_CYC): cs_n=0, we_n=1. On the last READ edge: rsp_rdata <= ~ram_o_n.
//  - RESP (1 cycle): cs_n=1, we_n=1, rsp_valid=1. Next state is IDLE.
//  - Latency from accept edge to rsp_valid high:
//    write = SETUP+PULSE+HOLD+1 (5 cycles default); read = READ_CYC+1 (3 cycles default).
//  - Min request spacing: write 6 cycles, read 4 cycles (default parameters).
//  - ram_we_n is never low unless ram_cs_n is low. ram_a and ram_d never change while
//    ram_we_n=0 or during HOLD.
//  - rsp_rdata holds its value until the next read capture. Writes do not alter it.
//  - ram_a/ram_d keep their last values in IDLE/RESP. They are only re-driven on accept.
//  - Reset mid-transaction: next edge forces IDLE with cs_n=we_n=1 and no rsp_valid.
//    A write aborted after WE fell may already be committed in the RAM. Nothing is retried.
//  - Phase counter width = clog2(max param + 1). It reloads on every state entry.
//    A parameter value of 0 is illegal; elaboration-time check.
// STRUCTURE
//  - Package sap_ram_pkg holds the state encoding (IDLE, SETUP, PULSE, HOLD, READ, RESP)
//    and the default timing constants shared with the loader/sequencer.
//  - Sub-module ram_phase_timer: loadable down-counter with load value and done flag,
//    used for all timed phases.
//  - The top level holds the FSM, request latches, output registers and the read inversion.
// TESTING (bench uses a behavioural two-chip 16x8 model with negedge-WE write, inverted out)
//  - Reset then idle: ram_cs_n=1, ram_we_n=1, req_ready=1, rsp_valid=0 for 10 cycles.
//  - Write a=0x3 d=0xA5 accepted at edge 0 -> cs_n low at cycles 1-4, we_n low at cycles 2-3,
//    rsp_valid at cycle 5. Model mem[3]=0xA5.
//  - Read a=0x3 after that write -> rsp_valid 3 cycles after accept, rsp_rdata=0xA5
//    (not 0x5A).
//  - Write 0x00..0x0F to addresses 0..15 back-to-back, then read all 16 -> each readback
//    matches. req_ready is low during every transaction.
//  - req_valid held high with changing addr mid-write -> the in-flight write uses the
//    original addr. The second request is taken only in IDLE.
//  - rst asserted in PULSE -> next cycle cs_n=1, we_n=1, req_ready=1, no rsp_valid.
//    A following read works normally.

Source files
------------

// File: rtl/sap_ram_pkg.sv
// Shared state encoding and default timing for the SAP 74189 RAM path.
// Used by the RAM initiator and by the loader/sequencer.
package sap_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_READ,
        ST_RESP
    } state_e;

    localparam int unsigned SAP_AW        = 4;
    localparam int unsigned SAP_DW        = 8;
    localparam int unsigned SAP_SETUP_CYC = 1;
    localparam int unsigned SAP_PULSE_CYC = 2;
    localparam int unsigned SAP_HOLD_CYC  = 1;
    localparam int unsigned SAP_READ_CYC  = 2;

    function automatic int unsigned max_cyc(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ram_phase_timer.sv
// Loadable down-counter timing each RAM strobe phase.
// done_o is high during the last cycle of the loaded phase.
module ram_phase_timer #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/sram189_ctrl.sv
// Valid/ready initiator for two 74189 16x4 RAMs forming a 16x8 store.
// Generates registered CS/WE strobes and re-inverts the chips' outputs.
module sram189_ctrl
    import sap_ram_pkg::*;
#(
    parameter int unsigned AW        = SAP_AW,
    parameter int unsigned DW        = SAP_DW,
    parameter int unsigned SETUP_CYC = SAP_SETUP_CYC,
    parameter int unsigned PULSE_CYC = SAP_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = SAP_HOLD_CYC,
    parameter int unsigned READ_CYC  = SAP_READ_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_cs_n,
    output logic          ram_we_n,
    input  logic [DW-1:0] ram_o_n
);

    localparam int unsigned MAXC =
        max_cyc(SETUP_CYC, PULSE_CYC, HOLD_CYC, READ_CYC);
    localparam int unsigned CW = $clog2(MAXC + 1);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 ||
        HOLD_CYC < 1 || READ_CYC < 1) begin : g_bad_param
        $error("sram189_ctrl: timing parameters must be >= 1");
    end

    state_e        state_q;
    state_e        state_d;
    logic          cs_n_q;
    logic          we_n_q;
    logic [AW-1:0] a_q;
    logic [DW-1:0] d_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rdata_q;

    logic          accept;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_done;

    assign accept = (state_q == ST_IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (req_valid) state_d = req_we ? ST_SETUP : ST_READ;
            ST_SETUP: if (tmr_done) state_d = ST_PULSE;
            ST_PULSE: if (tmr_done) state_d = ST_HOLD;
            ST_HOLD:  if (tmr_done) state_d = ST_RESP;
            ST_READ:  if (tmr_done) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Every state entry reloads the timer with that phase's length.
    assign tmr_load = (state_d != state_q);

    always_comb begin
        tmr_val = CW'(1);
        unique case (state_d)
            ST_SETUP: tmr_val = CW'(SETUP_CYC);
            ST_PULSE: tmr_val = CW'(PULSE_CYC);
            ST_HOLD:  tmr_val = CW'(HOLD_CYC);
            ST_READ:  tmr_val = CW'(READ_CYC);
            default:  tmr_val = CW'(1);
        endcase
    end

    ram_phase_timer #(
        .CW(CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Strobes are decoded from the next state so they align with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            a_q         <= '0;
            d_q         <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cs_n_q      <= (state_d == ST_IDLE) || (state_d == ST_RESP);
            we_n_q      <= (state_d != ST_PULSE);
            rsp_valid_q <= (state_d == ST_RESP);
            if (accept) begin
                a_q <= req_addr;
                d_q <= req_wdata;
            end
            if (state_q == ST_READ && state_d == ST_RESP) begin
                rdata_q <= ~ram_o_n;
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign ram_a     = a_q;
    assign ram_d     = d_q;
    assign ram_cs_n  = cs_n_q;
    assign ram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram189_ctrl.sv
// Bench for sram189_ctrl: two-chip 74189 model (negedge-WE write,
// inverted outputs) plus a word-level reference memory.
module tb_sram189_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic [3:0] ram_a;
    logic [7:0] ram_d;
    logic       ram_cs_n;
    logic       ram_we_n;
    logic [7:0] ram_o_n;

    logic [7:0] chip_mem [16];
    logic [7:0] ref_mem  [16];
    logic [7:0] ref_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram189_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_cs_n  (ram_cs_n),
        .ram_we_n  (ram_we_n),
        .ram_o_n   (ram_o_n)
    );

    // 74189 pair: commit on WE falling edge while selected, inverted data out.
    always @(negedge ram_we_n) begin
        if (ram_cs_n === 1'b0) chip_mem[ram_a] = ram_d;
    end

    assign ram_o_n = (ram_cs_n === 1'b0 && ram_we_n === 1'b1)
                     ? ~chip_mem[ram_a] : 8'hFF;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One request; checks every cycle from accept until the bus is idle again.
    // With keep set, req_valid stays high and the request fields change to a2/d2.
    task automatic txn(input logic we, input logic [3:0] a, input logic [7:0] d,
                       input logic keep, input logic [3:0] a2,
                       input logic [7:0] d2);
        int lat;
        int w;
        logic [7:0] prev;
        lat = we ? 5 : 3;
        prev = ref_rdata;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_timeout", 32'(w < 20), 32'd1);
        @(negedge clk);
        if (keep) begin
            req_addr  = a2;
            req_wdata = d2;
        end else begin
            req_valid = 1'b0;
        end
        if (we) ref_mem[a] = d;
        for (int n = 1; n <= lat + 1; n++) begin
            chk("req_ready", 32'(req_ready), 32'(n > lat));
            chk("busy", 32'(busy), 32'(n <= lat));
            chk("rsp_valid", 32'(rsp_valid), 32'(n == lat));
            chk("ram_cs_n", 32'(ram_cs_n), 32'(n >= lat));
            chk("ram_we_n", 32'(ram_we_n), 32'(!(we && (n == 2 || n == 3))));
            if (n < lat) chk("ram_a", 32'(ram_a), 32'(a));
            if (we && n < lat) chk("ram_d", 32'(ram_d), 32'(d));
            chk("rsp_rdata", 32'(rsp_rdata),
                32'((!we && n >= lat) ? ref_mem[a] : prev));
            if (n <= lat) @(negedge clk);
        end
        if (!we) ref_rdata = ref_mem[a];
    endtask

    initial begin
        int order [16];
        int j;
        int tmp;
        logic       rwe;
        logic [3:0] ra;
        logic [7:0] rd;

        for (int i = 0; i < 16; i++) begin
            chip_mem[i] = 8'($urandom);
            ref_mem[i]  = 8'h00;
        end
        ref_rdata = 8'h00;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 4'h0;
        req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_ram_a", 32'(ram_a), 32'h0);
        chk("rst_ram_d", 32'(ram_d), 32'h0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_cs_n", 32'(ram_cs_n), 32'd1);
            chk("idle_we_n", 32'(ram_we_n), 32'd1);
            chk("idle_ready", 32'(req_ready), 32'd1);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        txn(1'b1, 4'h3, 8'hA5, 1'b0, 4'h0, 8'h00);
        chk("model_mem3", 32'(chip_mem[3]), 32'hA5);
        txn(1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 8'h00);
        chk("read_a5", 32'(rsp_rdata), 32'hA5);

        for (int i = 0; i < 16; i++) txn(1'b1, 4'(i), 8'(i), 1'b0, 4'h0, 8'h00);
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 16; i++)
            txn(1'b0, 4'(order[i]), 8'h00, 1'b0, 4'h0, 8'h00);

        for (int k = 0; k < 24; k++) begin
            rwe = 1'($urandom);
            ra  = 4'($urandom);
            rd  = 8'($urandom);
            txn(rwe, ra, rd, 1'b0, 4'h0, 8'h00);
        end

        txn(1'b1, 4'h6, 8'h5E, 1'b1, 4'hB, 8'hC7);
        txn(1'b1, 4'hB, 8'hC7, 1'b0, 4'h0, 8'h00);
        txn(1'b0, 4'h6, 8'h00, 1'b0, 4'h0, 8'h00);
        txn(1'b0, 4'hB, 8'h00, 1'b0, 4'h0, 8'h00);

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'h9;
        req_wdata = 8'h3C;
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_setup_cs_n", 32'(ram_cs_n), 32'd0);
        chk("abort_setup_we_n", 32'(ram_we_n), 32'd1);
        @(negedge clk);
        chk("abort_pulse_we_n", 32'(ram_we_n), 32'd0);
        rst = 1'b1;
        ref_mem[9] = 8'h3C;
        ref_rdata  = 8'h00;
        @(negedge clk);
        chk("abort_cs_n", 32'(ram_cs_n), 32'd1);
        chk("abort_we_n", 32'(ram_we_n), 32'd1);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid_late", 32'(rsp_valid), 32'd0);
        txn(1'b0, 4'h9, 8'h00, 1'b0, 4'h0, 8'h00);
        txn(1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
